// File: rtl/rx_fcs_stripper.sv
// rx_fcs_stripper: strips preamble/SFD and FCS from a GMII rx stream, flags the last beat on CRC/runt/oversize.
// Optional statistics counters are enabled by defining RX_STATS_EN.
module rx_fcs_stripper #(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int STATS_W         = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid_i,
  input  logic [7:0]         rx_data_i,
  input  logic               is_preamble_or_sfd_i,
  input  logic               crc_error_i,
  output logic               m_valid_o,
  output logic [7:0]         m_data_o,
  output logic               m_last_o,
  output logic               m_error_o,
  output logic [STATS_W-1:0] frames_ok_o,
  output logic [STATS_W-1:0] frames_err_o
);
  localparam int CW = $clog2(MAX_FRAME_BYTES + 2);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_FRAME_BYTES + 1);
  localparam logic [CW-1:0] CNT_MIN = CW'(MIN_FRAME_BYTES);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_FRAME_BYTES);
  typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_e;
  state_e          r_state, w_next_state;
  logic            r_prev_valid;
  logic [7:0]      r_dl [5];
  logic [CW-1:0]   r_cnt;
  logic            w_start, w_end, w_shift, w_has5, w_bad;
  logic            w_m_valid, w_m_last, w_m_error;
  logic [7:0]      w_m_data;
  // Same start rule as the CRC checker: valid for two cycles and past the SFD.
  assign w_start = (r_state == IDLE) & rx_valid_i & r_prev_valid & ~is_preamble_or_sfd_i;
  assign w_end   = (r_state == FRAME) & ~rx_valid_i;
  assign w_shift = w_start | ((r_state == FRAME) & rx_valid_i);
  assign w_has5  = r_cnt >= CW'(5);
  assign w_bad   = crc_error_i | (r_cnt < CNT_MIN) | (r_cnt > CNT_MAX);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end
  always_comb begin
    w_next_state = w_start ? FRAME : w_end ? IDLE : r_state;
  end
  always_comb begin
    w_m_valid = (r_state == FRAME) & w_has5;
    w_m_last  = w_end & w_has5;
    w_m_error = w_m_last & w_bad;
    w_m_data  = w_m_valid ? r_dl[4] : 8'h00;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_valid <= 1'b0;
      r_cnt        <= '0;
      for (int i = 0; i < 5; i++) r_dl[i] <= 8'h00;
      m_valid_o    <= 1'b0;
      m_data_o     <= 8'h00;
      m_last_o     <= 1'b0;
      m_error_o    <= 1'b0;
    end else begin
      r_prev_valid <= rx_valid_i;
      m_valid_o    <= w_m_valid;
      m_data_o     <= w_m_data;
      m_last_o     <= w_m_last;
      m_error_o    <= w_m_error;
      if (w_shift) begin
        r_dl[0] <= rx_data_i;
        for (int i = 1; i < 5; i++) r_dl[i] <= r_dl[i-1];
        r_cnt <= w_start ? CW'(1) : (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CW'(1);
      end else if (w_end) begin
        for (int i = 0; i < 5; i++) r_dl[i] <= 8'h00;
        r_cnt <= '0;
      end
    end
  end
`ifdef RX_STATS_EN
  logic [STATS_W-1:0] r_ok, r_err;
  logic               w_drop;
  assign w_drop = w_end & ~w_has5;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ok  <= '0;
      r_err <= '0;
    end else begin
      if (w_m_last & ~w_m_error & ~&r_ok) r_ok <= r_ok + STATS_W'(1);
      if ((w_m_error | w_drop) & ~&r_err) r_err <= r_err + STATS_W'(1);
    end
  end
  assign frames_ok_o  = r_ok;
  assign frames_err_o = r_err;
`else
  assign frames_ok_o  = '0;
  assign frames_err_o = '0;
`endif
endmodule

// File: tb/tb_rx_fcs_stripper.sv
// tb_rx_fcs_stripper: randomized frames checked every cycle against a queue of expected payload beats.
module tb_rx_fcs_stripper;
  logic clk = 1'b0, rst = 1'b1;
  logic rx_valid_i = 1'b0, is_preamble_or_sfd_i = 1'b0, crc_error_i = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic m_valid_o, m_last_o, m_error_o;
  logic [7:0] m_data_o;
  logic [31:0] frames_ok_o, frames_err_o;
  rx_fcs_stripper dut (
    .clk(clk), .rst(rst), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .is_preamble_or_sfd_i(is_preamble_or_sfd_i), .crc_error_i(crc_error_i),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o), .m_error_o(m_error_o),
    .frames_ok_o(frames_ok_o), .frames_err_o(frames_err_o)
  );
  always #5 clk = ~clk;
  typedef struct {logic [7:0] d; logic l; logic e; int c;} beat_t;
  beat_t q[$];
  int cyc = 0, checks = 0, failures = 0;
  int beats = 0, total_beats = 0, first_cyc = 0, c0 = 0, ok_cnt = 0, err_cnt = 0;
  logic last_err = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Per-cycle compare: an output beat must appear exactly in the cycle the model predicts.
  always @(negedge clk) begin
    beat_t b;
    while (q.size() > 0 && q[0].c < cyc) begin
      b = q.pop_front();
      failures++; checks++;
      $display("FAIL missing_beat: got none expected data %02h at cycle %0d", b.d, b.c);
    end
    if (q.size() > 0 && q[0].c == cyc) begin
      b = q.pop_front();
      checks++;
      if (!(m_valid_o === 1'b1 && m_data_o === b.d && m_last_o === b.l && m_error_o === b.e)) begin
        failures++;
        $display("FAIL beat: got v=%b d=%02h l=%b e=%b expected v=1 d=%02h l=%b e=%b cycle %0d",
                 m_valid_o, m_data_o, m_last_o, m_error_o, b.d, b.l, b.e, cyc);
      end
      if (beats == 0) first_cyc = cyc;
      beats++; total_beats++;
      if (b.l) last_err = m_error_o;
    end else if (m_valid_o !== 1'b0 || m_last_o !== 1'b0 || m_error_o !== 1'b0) begin
      checks++; failures++;
      $display("FAIL spurious: got v=%b l=%b e=%b expected all 0 cycle %0d", m_valid_o, m_last_o, m_error_o, cyc);
    end
  end
  task automatic step(input logic v, input logic [7:0] d, input logic p, input logic e);
    @(posedge clk); #1;
    rx_valid_i = v; rx_data_i = d; is_preamble_or_sfd_i = p; crc_error_i = e;
  endtask
  task automatic preamble();
    repeat (7) step(1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b1, 8'hD5, 1'b1, 1'b0);
  endtask
  task automatic check_counts();
`ifdef RX_STATS_EN
    check("frames_ok", frames_ok_o, ok_cnt);
    check("frames_err", frames_err_o, err_cnt);
`else
    check("frames_ok_tied", frames_ok_o, 0);
    check("frames_err_tied", frames_err_o, 0);
`endif
  endtask
  // Model: payload is bytes 0..n-5; byte k shows 6 cycles after input, last beat 1 cycle after valid falls.
  task automatic send_frame(input int n, input bit crc, input int gap, input int exp_beats, input int exp_err);
    logic [7:0] pl[$];
    bit err;
    err = crc || n < 64 || n > 1518;
    for (int k = 0; k < n; k++) pl.push_back(8'($urandom));
    preamble();
    c0 = cyc + 1;
    beats = 0;
    for (int k = 0; k <= n - 5; k++)
      q.push_back('{pl[k], k == n - 5, (k == n - 5) && err, (k < n - 5) ? c0 + k + 6 : c0 + n + 1});
    if (n <= 4 || err) err_cnt++; else ok_cnt++;
    for (int k = 0; k < n; k++) step(1'b1, pl[k], 1'b0, 1'($urandom_range(0, 1)));
    step(1'b0, 8'h00, 1'b0, crc);
    for (int k = 1; k < gap; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
    if (gap >= 2) begin
      @(negedge clk); #1;
      if (exp_beats >= 0) check($sformatf("beats_n%0d", n), beats, exp_beats);
      if (exp_beats > 0) check("first_latency", first_cyc - c0, 6);
      if (exp_err >= 0) check("last_error", last_err, exp_err);
      check_counts();
    end
  endtask
  initial begin
    #200_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    int tb0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", m_valid_o, 0);
    check("reset_last", m_last_o, 0);
    check_counts();
    #1 rst = 1'b0;
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    send_frame(64, 1'b0, 3, 60, 0);
    send_frame(64, 1'b1, 3, 60, 1);
    send_frame(40, 1'b0, 3, 36, 1);
    send_frame(3, 1'b0, 3, 0, -1);
    send_frame(5, 1'b0, 3, 1, 1);
    send_frame(1519, 1'b0, 3, 1515, 1);
    send_frame(1518, 1'b0, 3, 1514, 0);
    tb0 = total_beats;
    send_frame(64, 1'b0, 1, -1, -1);
    send_frame(64, 1'b0, 3, 60, 0);
    check("back_to_back_beats", total_beats - tb0, 120);
    repeat (3) step(1'b1, 8'h55, 1'b1, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);
    check_counts();
    preamble();
    c0 = cyc + 1;
    for (int k = 0; k < 30; k++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if (k <= 23) q.push_back('{d, 1'b0, 1'b0, c0 + k + 6});
      step(1'b1, d, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b1; rx_valid_i = 1'b0;
    ok_cnt = 0; err_cnt = 0;
    @(negedge clk);
    check("rst_mid_valid", m_valid_o, 0);
    check("rst_mid_last", m_last_o, 0);
    check_counts();
    @(posedge clk); #1 rst = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    send_frame(64, 1'b0, 3, 60, 0);
    for (int f = 0; f < 25; f++) begin
      int n;
      n = $urandom_range(1, 90);
      send_frame(n, 1'($urandom_range(0, 3) == 0), $urandom_range(2, 4), n >= 5 ? n - 4 : 0, -1);
    end
    repeat (10) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
